// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_pkg;

  localparam int SPI_FRAME_WIDTH = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_DONE  = 2'd2
  } SPI_RX_STATE;

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchroniser for asynchronous SPI pins; resets to 0.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the pin through the flop chain; the last flop is the clean copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI front end: synchronises sck/sdi/cs into clk and deserialises one
// WIDTH-bit MSB-first frame per cs assertion. Optional MISO path is enabled
// with the SPI_SDO_EN macro (adds tx_data/sdo).
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_FRAME_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SPI_SDO_EN
  input  logic [WIDTH-1:0] tx_data,
  output logic             sdo,
`endif
  input  logic             sck,
  input  logic             sdi,
  input  logic             cs,
  output logic             cs_sync,
  output logic [WIDTH-1:0] data,
  output logic             frame_valid,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);

  logic w_sck_s, w_sdi_s, w_cs_s;
  logic w_sck_rise, w_sck_fall, w_cs_rise;
  logic w_enter_done, w_good_nxt;

  SPI_RX_STATE      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             r_sck_prev, r_cs_prev;
  logic [FW-1:0]    r_fill;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, r_err;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .reset(reset), .i_d(sck), .o_q(w_sck_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (.clk(clk), .reset(reset), .i_d(sdi), .o_q(w_sdi_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs  (.clk(clk), .reset(reset), .i_d(cs),  .o_q(w_cs_s));

  assign w_sck_rise = w_sck_s & ~r_sck_prev;
  assign w_sck_fall = ~w_sck_s & r_sck_prev;
  assign w_cs_rise  = w_cs_s & ~r_cs_prev;

  // Previous-value flops for edge detection. Previous-cs is held at 1 until the
  // cs synchroniser has refilled after reset, so its reset zeros never look
  // like a low cs and a cs already high at release cannot start a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b1;
      r_fill     <= '0;
    end else begin
      r_sck_prev <= w_sck_s;
      if (r_fill == FILL_DONE) begin
        r_cs_prev <= w_cs_s;
      end else begin
        r_cs_prev <= 1'b1;
        r_fill    <= r_fill + FW'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next shift/count/overrun values.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_ovr_nxt   = r_ovr;
    case (r_state)
      RX_IDLE: begin
        if (w_cs_rise) begin
          w_state_nxt = RX_SHIFT;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_ovr_nxt   = 1'b0;
        end
      end
      RX_SHIFT: begin
        // An sck edge coincident with cs going low is still taken.
        if (w_sck_rise) begin
          if (r_cnt < CNT_FULL) begin
            w_shift_nxt = {r_shift[WIDTH-2:0], w_sdi_s};
            w_cnt_nxt   = r_cnt + CW'(1);
          end else begin
            w_ovr_nxt = 1'b1;
          end
        end
        if (!w_cs_s) w_state_nxt = RX_DONE;
      end
      RX_DONE:  w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  assign w_enter_done = (r_state == RX_SHIFT) && !w_cs_s;
  assign w_good_nxt   = (w_cnt_nxt == CNT_FULL) && !w_ovr_nxt;

  // Shift register, bit count and overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Result word and the one-cycle pulses that coincide with RX_DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_enter_done & w_good_nxt;
      r_err   <= w_enter_done & ~w_good_nxt;
      if (w_enter_done && w_good_nxt) r_data <= w_shift_nxt;
    end
  end

  assign cs_sync     = w_cs_s;
  assign data        = r_data;
  assign frame_valid = r_valid;
  assign frame_err   = r_err;

`ifdef SPI_SDO_EN
  logic [WIDTH-1:0] r_tx;

  // Transmit word latched at frame start, shifted out MSB-first on sck falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx <= '0;
    end else if (r_state == RX_IDLE && w_cs_rise) begin
      r_tx <= tx_data;
    end else if (r_state == RX_SHIFT && w_sck_fall) begin
      r_tx <= {r_tx[WIDTH-2:0], 1'b0};
    end
  end

  assign sdo = (r_state == RX_SHIFT) ? r_tx[WIDTH-1] : 1'b0;
`else
  logic w_unused_fall;
  assign w_unused_fall = w_sck_fall;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: an MCU model drives frames, expected
// pulses are queued, and a monitor checks every pulse the DUT presents.
module tb_spi_frame_rx;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset, sck, sdi, cs;
  logic cs_sync, frame_valid, frame_err;
  logic [W-1:0] data;
`ifdef SPI_SDO_EN
  logic [W-1:0] tx_data;
  logic sdo;
`endif

  spi_frame_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SPI_SDO_EN
    .tx_data(tx_data),
    .sdo(sdo),
`endif
    .sck(sck),
    .sdi(sdi),
    .cs(cs),
    .cs_sync(cs_sync),
    .data(data),
    .frame_valid(frame_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_err;
    logic [W-1:0] d;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] last_good;
  int           errors = 0;
  int           checks = 0;
  int           since_rst = 0;
  logic [1:0]   hist = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // cs history as seen at each clock edge, for the cs_sync delay check.
  always @(posedge clk) begin
    if (reset) since_rst = 0;
    else since_rst++;
    hist = {hist[0], cs};
  end

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (since_rst >= 3) chk("cs_sync", 32'(cs_sync), 32'(hist[1]));
      if (frame_valid && frame_err) chk("both_pulses", 32'(1), 32'(0));
      if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({frame_valid, frame_err}), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 32'(frame_err), 32'(e.is_err));
          chk("data", 32'(data), 32'(e.d));
        end
      end
    end
  end

  // MCU model: bits of val[nbits-1:0] MSB first, sdi set in the low phase.
  task automatic send_frame(input int nbits, input logic [31:0] val,
                            input logic [W-1:0] txw, input logic [W-1:0] tx_mid,
                            input int gap);
    logic [31:0] got;
    exp_t e;
    got = '0;
`ifdef SPI_SDO_EN
    tx_data = txw;
`endif
    cs = 1'b1;
    step(2);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = val[i];
      step(4);
      sck = 1'b1;
`ifdef SPI_SDO_EN
      got = {got[30:0], sdo};
      if (i == nbits / 2) tx_data = tx_mid;
`endif
      step(4);
      sck = 1'b0;
    end
    step(4);
    cs = 1'b0;
    if (nbits == W) begin
      last_good = val[W-1:0];
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.d = last_good;
    exp_q.push_back(e);
`ifdef SPI_SDO_EN
    if (nbits == W) chk("sdo_word", got, 32'(txw));
`else
    if (txw != tx_mid) got = '0;
`endif
    step(gap);
  endtask

  initial begin
    int kind, nb;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs = 1'b0;
`ifdef SPI_SDO_EN
    tx_data = '0;
`endif
    last_good = '0;
    step(3);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_cs_sync", 32'(cs_sync), 32'h0);
    reset = 1'b0;
    step(4);

    send_frame(16, 32'h0000A5C3, 16'h5A5A, 16'h1111, 6);
    send_frame(12, 32'h00000ABC, 16'h0F0F, 16'h2222, 6);
    send_frame(18, {14'h0, 16'h00FF, 2'b10}, 16'hC0DE, 16'h3333, 6);

    // Reset in the middle of a frame with cs held high throughout.
    cs = 1'b1;
    step(2);
    for (int i = 0; i < 8; i++) begin
      sdi = i[0]; step(4); sck = 1'b1; step(4); sck = 1'b0;
    end
    reset = 1'b1;
    last_good = '0;
    step(2);
    chk("midrst_data", 32'(data), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sdi = i[1]; step(4); sck = 1'b1; step(4); sck = 1'b0;
    end
    step(4);
    cs = 1'b0;
    step(8);
    send_frame(16, 32'h00001234, 16'hAAAA, 16'h5555, 6);

    send_frame(16, 32'h00000001, 16'h1234, 16'h4321, 4);
    send_frame(16, 32'h0000FFFE, 16'hFFFF, 16'h0000, 4);
    send_frame(16, 32'h00003C3C, 16'h8001, 16'h0000, 6);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      if (kind == 0)      nb = $urandom_range(1, W - 1);
      else if (kind == 1) nb = $urandom_range(W + 1, W + 4);
      else                nb = W;
      send_frame(nb, $urandom, W'($urandom), W'($urandom), $urandom_range(4, 8));
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step(1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
